// File: rtl/cheri_tsmap_arbiter.sv
// Temporal-safety map SRAM arbiter: core read port always wins,
// revoker and writer share idle cycles round-robin.
module cheri_tsmap_arbiter #(
  parameter int unsigned TSMapSize   = 1024,
  parameter int unsigned AddrW       = 16,
  parameter int unsigned StarveLimit = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             core_cs_i,
  input  logic [AddrW-1:0] core_addr_i,
  output logic [31:0]      core_rdata_o,
  input  logic             rvk_req_i,
  input  logic [AddrW-1:0] rvk_addr_i,
  output logic             rvk_gnt_o,
  output logic             rvk_rvalid_o,
  output logic [31:0]      rvk_rdata_o,
  input  logic             wr_req_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [31:0]      wr_wdata_i,
  input  logic [3:0]       wr_be_i,
  output logic             wr_gnt_o,
  output logic             mem_cs_o,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic [3:0]       mem_be_o,
  input  logic [31:0]      mem_rdata_i,
  output logic             oor_err_o,
  output logic             starve_o,
  input  logic             starve_clr_i
);

  localparam int unsigned CntW = $clog2(StarveLimit + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);
  localparam logic [AddrW:0] MapEnd = (AddrW + 1)'(TSMapSize);

  typedef enum logic [1:0] {
    OwnNone,
    OwnCore,
    OwnRvk
  } owner_e;

  owner_e          rd_owner_q, owner_d;
  logic            oor_q, oor_d;
  logic            rr_q;
  logic [CntW-1:0] wait_cnt_q, cnt_d;
  logic            starve_q, starve_d;

  logic             core_act, bg_free;
  logic             rvk_win, wr_win, bg_gnt;
  logic             acc, sel_oor, sel_we;
  logic [AddrW-1:0] sel_addr;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_be;

  // Grant decision: core first, then round-robin between background ports.
  always_comb begin
    core_act = rst_ni & core_cs_i;
    bg_free  = rst_ni & ~core_cs_i;
    rvk_win  = bg_free & rvk_req_i & (~wr_req_i | ~rr_q);
    wr_win   = bg_free & wr_req_i & (~rvk_req_i | rr_q);
    bg_gnt   = rvk_win | wr_win;
  end

  // Select the winning request and range-check its address.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    sel_we    = 1'b0;
    sel_oor   = 1'b0;
    unique case (1'b1)
      core_act: begin
        sel_addr = core_addr_i;
        sel_oor  = {1'b0, core_addr_i} >= MapEnd;
      end
      rvk_win: begin
        sel_addr = rvk_addr_i;
        sel_oor  = {1'b0, rvk_addr_i} >= MapEnd;
      end
      wr_win: begin
        sel_addr  = wr_addr_i;
        sel_wdata = wr_wdata_i;
        sel_be    = wr_be_i;
        sel_we    = 1'b1;
        sel_oor   = {1'b0, wr_addr_i} >= MapEnd;
      end
      default: ;
    endcase
    acc = core_act | rvk_win | wr_win;
  end

  // SRAM drive; out-of-range accesses never reach the macro.
  always_comb begin
    mem_cs_o    = acc & ~sel_oor;
    mem_we_o    = mem_cs_o & sel_we;
    mem_addr_o  = mem_cs_o ? sel_addr : '0;
    mem_wdata_o = mem_we_o ? sel_wdata : '0;
    mem_be_o    = mem_we_o ? sel_be : '0;
    oor_err_o   = acc & sel_oor;
    rvk_gnt_o   = rvk_win;
    wr_gnt_o    = wr_win;
  end

  // Next-state for return tag and starvation counter.
  always_comb begin
    owner_d = OwnNone;
    if (core_act) begin
      owner_d = OwnCore;
    end else if (rvk_win) begin
      owner_d = OwnRvk;
    end
    oor_d = (core_act | rvk_win) & sel_oor;
    cnt_d = wait_cnt_q;
    if (starve_clr_i || bg_gnt) begin
      cnt_d = '0;
    end else if ((rvk_req_i || wr_req_i) && wait_cnt_q != CntMax) begin
      cnt_d = wait_cnt_q + CntW'(1);
    end
    starve_d = starve_q;
    if (starve_clr_i) begin
      starve_d = 1'b0;
    end else if (cnt_d == CntMax) begin
      starve_d = 1'b1;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= 1'b0;
      rd_owner_q <= OwnNone;
      oor_q      <= 1'b0;
      wait_cnt_q <= '0;
      starve_q   <= 1'b0;
    end else begin
      if (rvk_win) begin
        rr_q <= 1'b1;
      end else if (wr_win) begin
        rr_q <= 1'b0;
      end
      rd_owner_q <= owner_d;
      oor_q      <= oor_d;
      wait_cnt_q <= cnt_d;
      starve_q   <= starve_d;
    end
  end

  // Steer returning SRAM data to the port that issued the read.
  always_comb begin
    core_rdata_o = '0;
    rvk_rdata_o  = '0;
    rvk_rvalid_o = rd_owner_q == OwnRvk;
    if (rd_owner_q == OwnCore && !oor_q) begin
      core_rdata_o = mem_rdata_i;
    end
    if (rd_owner_q == OwnRvk && !oor_q) begin
      rvk_rdata_o = mem_rdata_i;
    end
    starve_o = starve_q;
  end

endmodule

// File: tb/tb_cheri_tsmap_arbiter.sv
// Directed bench for cheri_tsmap_arbiter with a
// behavioural 1-cycle SRAM model.
module tb_cheri_tsmap_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_cs_i;
  logic [15:0] core_addr_i;
  logic [31:0] core_rdata_o;
  logic        rvk_req_i;
  logic [15:0] rvk_addr_i;
  logic        rvk_gnt_o;
  logic        rvk_rvalid_o;
  logic [31:0] rvk_rdata_o;
  logic        wr_req_i;
  logic [15:0] wr_addr_i;
  logic [31:0] wr_wdata_i;
  logic [3:0]  wr_be_i;
  logic        wr_gnt_o;
  logic        mem_cs_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i = '0;
  logic        oor_err_o;
  logic        starve_o;
  logic        starve_clr_i;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int passes = 0;
  int gnt_seen = 0;

  cheri_tsmap_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_cs_i(core_cs_i), .core_addr_i(core_addr_i),
    .core_rdata_o(core_rdata_o),
    .rvk_req_i(rvk_req_i), .rvk_addr_i(rvk_addr_i),
    .rvk_gnt_o(rvk_gnt_o), .rvk_rvalid_o(rvk_rvalid_o),
    .rvk_rdata_o(rvk_rdata_o),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i),
    .wr_wdata_i(wr_wdata_i), .wr_be_i(wr_be_i),
    .wr_gnt_o(wr_gnt_o),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
    .oor_err_o(oor_err_o), .starve_o(starve_o),
    .starve_clr_i(starve_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // SRAM model: byte-enabled write, registered read.
  always @(posedge clk_i) begin
    if (mem_cs_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_o[b]) mem[mem_addr_o[9:0]][8*b +: 8] = mem_wdata_o[8*b +: 8];
        end
      end else begin
        mem_rdata_i <= mem[mem_addr_o[9:0]];
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    mem[5] = 32'hA5A5_0001;
    rst_ni = 1'b0;
    core_cs_i = 0; core_addr_i = 0;
    rvk_req_i = 0; rvk_addr_i = 0;
    wr_req_i = 0; wr_addr_i = 0; wr_wdata_i = 0; wr_be_i = 0;
    starve_clr_i = 0;
    repeat (3) tick();
    chk("rst_mem_cs", 32'(mem_cs_o), 0);
    chk("rst_rvalid", 32'(rvk_rvalid_o), 0);
    chk("rst_core_rdata", core_rdata_o, 0);
    chk("rst_starve", 32'(starve_o), 0);
    chk("rst_oor", 32'(oor_err_o), 0);
    rst_ni = 1'b1;
    tick();

    // core read of word 5
    core_cs_i = 1; core_addr_i = 5;
    #1;
    chk("core_cs", 32'(mem_cs_o), 1);
    chk("core_we", 32'(mem_we_o), 0);
    chk("core_addr", 32'(mem_addr_o), 5);
    tick();
    core_cs_i = 0;
    #1;
    chk("core_rdata5", core_rdata_o, 32'hA5A5_0001);
    chk("core_no_rvalid", 32'(rvk_rvalid_o), 0);

    // both background ports from reset pointer
    rvk_req_i = 1; rvk_addr_i = 10;
    wr_req_i = 1; wr_addr_i = 3; wr_wdata_i = 32'hFFFF_0000; wr_be_i = 4'b1100;
    #1;
    chk("rr0_rvk_gnt", 32'(rvk_gnt_o), 1);
    chk("rr0_wr_gnt", 32'(wr_gnt_o), 0);
    chk("rr0_addr", 32'(mem_addr_o), 10);
    tick();
    rvk_req_i = 0;
    #1;
    chk("rr1_wr_gnt", 32'(wr_gnt_o), 1);
    chk("rr1_we", 32'(mem_we_o), 1);
    chk("rr1_be", 32'(mem_be_o), 32'hC);
    chk("rr1_wdata", mem_wdata_o, 32'hFFFF_0000);
    chk("rvk_rvalid", 32'(rvk_rvalid_o), 1);
    chk("rvk_rdata10", rvk_rdata_o, 32'hA5A5_000A);
    tick();
    wr_req_i = 0;
    core_cs_i = 1; core_addr_i = 3;
    #1;
    chk("wr_no_rvalid", 32'(rvk_rvalid_o), 0);
    tick();
    core_cs_i = 0;
    #1;
    chk("be_upper_half", core_rdata_o, 32'hFFFF_0003);

    // starvation under continuous core traffic
    rvk_req_i = 1; rvk_addr_i = 20;
    core_cs_i = 1; core_addr_i = 0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (rvk_gnt_o) gnt_seen++;
      if (k == 63) chk("starve_pre", 32'(starve_o), 0);
      if (k == 64) chk("starve_set", 32'(starve_o), 1);
      if (k == 65) chk("cnt_sat", 32'(dut.wait_cnt_q), 64);
      if (k == 66) begin
        chk("starve_clr", 32'(starve_o), 0);
        chk("cnt_clr", 32'(dut.wait_cnt_q), 0);
      end
      starve_clr_i = (k == 65);
    end
    chk("no_rvk_gnt", 32'(gnt_seen), 0);
    core_cs_i = 0;
    #1;
    chk("starve_rvk_gnt", 32'(rvk_gnt_o), 1);
    chk("cnt_before_gnt", 32'(dut.wait_cnt_q), 4);
    tick();
    rvk_req_i = 0;
    #1;
    chk("cnt_after_gnt", 32'(dut.wait_cnt_q), 0);
    chk("starve_rvalid", 32'(rvk_rvalid_o), 1);
    chk("starve_rdata", rvk_rdata_o, 32'hA5A5_0014);

    // out-of-range accesses
    core_cs_i = 1; core_addr_i = 1024;
    #1;
    chk("oor_core_cs", 32'(mem_cs_o), 0);
    chk("oor_core_err", 32'(oor_err_o), 1);
    tick();
    core_cs_i = 0;
    #1;
    chk("oor_core_rdata", core_rdata_o, 0);
    chk("oor_err_pulse", 32'(oor_err_o), 0);
    rvk_req_i = 1; rvk_addr_i = 2000;
    #1;
    chk("oor_rvk_gnt", 32'(rvk_gnt_o), 1);
    chk("oor_rvk_cs", 32'(mem_cs_o), 0);
    chk("oor_rvk_err", 32'(oor_err_o), 1);
    tick();
    rvk_req_i = 0;
    #1;
    chk("oor_rvk_rvalid", 32'(rvk_rvalid_o), 1);
    chk("oor_rvk_rdata", rvk_rdata_o, 0);

    // same-address write and core read
    wr_req_i = 1; wr_addr_i = 7; wr_wdata_i = 32'h1234_5678; wr_be_i = 4'hF;
    core_cs_i = 1; core_addr_i = 7;
    #1;
    chk("coll_wr_gnt", 32'(wr_gnt_o), 0);
    chk("coll_we", 32'(mem_we_o), 0);
    tick();
    core_cs_i = 0;
    #1;
    chk("coll_old", core_rdata_o, 32'hA5A5_0007);
    chk("coll_wr_gnt2", 32'(wr_gnt_o), 1);
    tick();
    wr_req_i = 0;
    core_cs_i = 1; core_addr_i = 7;
    tick();
    core_cs_i = 0;
    #1;
    chk("coll_new", core_rdata_o, 32'h1234_5678);

    // reset right after a revoker grant
    rvk_req_i = 1; rvk_addr_i = 30;
    wr_req_i = 1; wr_addr_i = 8; wr_wdata_i = 32'h0; wr_be_i = 4'hF;
    #1;
    chk("pre_rst_rvk_gnt", 32'(rvk_gnt_o), 1);
    tick();
    rvk_req_i = 0;
    rst_ni = 1'b0;
    #1;
    chk("rst_drop_rvalid", 32'(rvk_rvalid_o), 0);
    chk("rst_wr_gnt", 32'(wr_gnt_o), 0);
    chk("rst_cs", 32'(mem_cs_o), 0);
    tick();
    chk("rst_hold_rvalid", 32'(rvk_rvalid_o), 0);
    wr_req_i = 0;
    rst_ni = 1'b1;
    tick();
    chk("post_rst_rvalid", 32'(rvk_rvalid_o), 0);
    rvk_req_i = 1; wr_req_i = 1;
    #1;
    chk("post_rst_rvk_gnt", 32'(rvk_gnt_o), 1);
    chk("post_rst_wr_gnt", 32'(wr_gnt_o), 0);
    tick();
    rvk_req_i = 0; wr_req_i = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cheri_tsmap_arbiter.md
# cheri_tsmap_arbiter

Arbiter that shares the single-port temporal-safety (revocation) map SRAM between three requesters: the core's load-filter read port, a background revoker read port, and a software/allocator write port. It sits beside the core in the CHERIoT top level, between the core's tsmap interface and the tsmap SRAM macro. The core port has fixed 1-cycle read latency and no back-pressure, so it always wins. The other two requesters are round-robined over idle cycles, with starvation detection and out-of-range address checking.

## Interface
- TSMapSize, 1024, map depth in 32-bit words; valid word addresses 0..TSMapSize-1
- AddrW, 16, word address width on all ports
- StarveLimit, 64, consecutive ungranted cycles of a pending background request that set starve_o (≥1)

- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- core_cs_i  in  1  core read strobe, single cycle
- core_addr_i  in  AddrW  core read word address
- core_rdata_o  out  32  core read data, valid the cycle after core_cs_i
- rvk_req_i  in  1  revoker read request, held until granted
- rvk_addr_i  in  AddrW  revoker word address, stable while rvk_req_i high
- rvk_gnt_o  out  1  revoker grant (combinational, same cycle as access)
- rvk_rvalid_o  out  1  revoker read data valid, cycle after grant
- rvk_rdata_o  out  32  revoker read data
- wr_req_i  in  1  write request, held until granted
- wr_addr_i  in  AddrW  write word address
- wr_wdata_i  in  32  write data
- wr_be_i  in  4  write byte enables
- wr_gnt_o  out  1  write grant (combinational)
- mem_cs_o / mem_we_o  out  1 each  SRAM chip select / write enable
- mem_addr_o  out  AddrW  SRAM word address
- mem_wdata_o / mem_be_o  out  32 / 4  SRAM write data / byte enables
- mem_rdata_i  in  32  SRAM read data, 1-cycle latency
- oor_err_o  out  1  one-cycle pulse on any out-of-range access
- starve_o  out  1  sticky starvation flag
- starve_clr_i  in  1  clears starve_o and the wait counter

## Operation
- Priority per cycle: core_cs_i > background round-robin (rvk vs wr) > idle.
- Round-robin pointer rr_q (reset 0 = rvk preferred). It is used only when rvk and wr both request and the core is idle. It toggles to the other port after each background grant. A lone requester is granted without consulting rr_q, and rr_q then points away from the granted port.
- Granted access drives mem_cs_o=1; mem_we_o=1 only for wr. Address, data and byte enables are muxed from the winner. mem_* outputs are 0 when idle.
- Out-of-range check (addr ≥ TSMapSize):
  - mem_cs_o stays 0 and oor_err_o pulses in the access cycle.
  - Core out-of-range read: core_rdata_o=0 next cycle.
  - Revoker out-of-range read: granted; rvalid next cycle with rdata 0.
  - Write out-of-range: granted and dropped.
- Return path: a registered tag rd_owner_q ∈ {NONE, CORE, RVK} plus an oor_q bit steer mem_rdata_i. The selected port gets mem_rdata_i, or 0 if oor_q. The non-selected port's data reads 0.
- Starvation: wait_cnt_q (width $clog2(StarveLimit+1), saturating) increments each cycle that (rvk_req_i|wr_req_i) is high with no background grant.
  - Reset to 0 on any background grant or starve_clr_i.
  - When it reaches StarveLimit, starve_o sets and holds until starve_clr_i.
  - If starve_clr_i coincides with the set condition, clear wins.
- Same-address write and core read in the same cycle: the core reads old data; the write completes in the next free cycle.

## Timing
- Reset values: rr_q=0, rd_owner_q=NONE, oor_q=0, wait_cnt_q=0, starve_o=0.
- In reset: all mem_* outputs, rvk_rvalid_o and oor_err_o are 0; core_rdata_o=0, rvk_rdata_o=0.
- Grants are combinational: requester sees gnt in cycle N; SRAM access occurs in N; read data and rvalid appear in N+1.
- Back-to-back: core may issue every cycle. A background port may be granted on consecutive cycles if uncontested.
- Reset asserted mid-access: any pending rvalid is discarded; no rvalid after reset release.
- Requesters must not drop req before gnt. Behaviour when a requester violates this is unspecified but must not corrupt the core path.

## Test plan
- Core read addr 5, SRAM word 5 = 32'hA5A5_0001 -> next cycle core_rdata_o=32'hA5A5_0001, rvk_rvalid_o=0.
- rvk_req and wr_req both high with core idle, from reset -> rvk granted cycle 0, wr granted cycle 1. Write to addr 3, data 32'hFFFF_0000, be 4'b1100 -> SRAM upper half updated.
- core_cs_i high every cycle for 70 cycles while rvk_req_i held -> no rvk_gnt_o. starve_o rises when wait_cnt reaches 64; a 1-cycle starve_clr_i drops it. After the core goes idle, rvk is granted and wait_cnt=0.
- Core read addr 1024 (TSMapSize=1024) -> mem_cs_o=0, oor_err_o pulse, core_rdata_o=0 next cycle. Revoker read addr 2000 -> gnt, rvalid with rdata 0.
- Write addr 7 and core read addr 7 in the same cycle -> core gets old value. Write is granted next cycle. Subsequent core read returns new value.
- Assert rst_ni low the cycle after a rvk grant -> rvk_rvalid_o=0 throughout and after release; rr_q back to 0.
